memory_arbiter: RTL
===================

# memory_arbiter

Shares one single-port synchronous memory between the instruction-fetch requester (L1I) and the data requester (L1D) through a req/ready handshake. Data accesses have priority; a streak counter bounds fetch starvation. The block sits between the L1 interfaces and the unified memory, and replaces the fixed "stall fetch while data is active" policy with a sequenced, fair arbiter.

## Interface
- ADDR_WIDTH, 32, address width of both requesters and memory
- DATA_WIDTH, 32, data width
- MAX_D_STREAK, 4, consecutive data grants allowed while a fetch is pending (range 1–15)

- clock  in  1  single clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request; held high until i_ready is seen
- i_address  in  ADDR_WIDTH  fetch address; stable while i_req is high
- i_ready  out  1  one-cycle pulse; fetch complete, i_rdata valid
- i_rdata  out  DATA_WIDTH  fetch data; registered, holds until the next fetch completes
- d_req  in  1  data request; held high until d_ready is seen
- d_write  in  1  1 = write, 0 = read; stable while d_req is high
- d_address  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  write data
- d_ready  out  1  one-cycle pulse; data access complete
- d_rdata  out  DATA_WIDTH  read data; registered, unchanged by writes
- stall_i  out  1  i_req && !i_ready
- stall_d  out  1  d_req && !d_ready
- mem_enable  out  1  memory access strobe
- mem_write  out  1  memory write enable; high only together with mem_enable
- mem_address  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data; valid one cycle after the strobe cycle

## Operation
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE, no request: stay in IDLE.
- IDLE, a request is present: select a winner, latch the winner's address/wdata/write into the mem_* registers, record the grant owner, and go to ACCESS.
- ACCESS: mem_enable=1. mem_write=1 only for a data write. Go to WAIT.
- WAIT: the memory drives mem_rdata. On a read, load the owner's rdata register from mem_rdata. Drive mem_enable=0 and mem_write=0. Go to DONE.
- DONE: pulse the owner's ready. Go to IDLE. Requests are not sampled in DONE.
- Arbitration in IDLE:
  - Only one request present: that requester wins.
  - Both present, streak < MAX_D_STREAK: data wins.
  - Both present, streak == MAX_D_STREAK: fetch wins.
- Streak counter: 4 bits, saturating.
  - Increments on a data grant while i_req is high.
  - Clears on a fetch grant, or on a data grant while i_req is low.
- mem_address and mem_wdata hold their last values outside ACCESS.
- Ready pulses are mutually exclusive and last exactly one cycle.

## Timing
- Single access latency: request sampled in cycle 0 (IDLE), strobe in cycle 1, data captured at the end of cycle 2, ready in cycle 3.
- Throughput: one access per 4 cycles. A request held through DONE is re-arbitrated in the IDLE cycle that follows.
- Both requests arriving in the same cycle: data completes in cycle 3; fetch is granted in cycle 4 and completes in cycle 7.
- A requester may drop req or change its address only after seeing ready. Dropping req mid-transaction does not abort it; ready still pulses.
- Reset values (applied immediately on reset_n low): state IDLE, streak 0, mem_enable 0, mem_write 0, mem_address 0, mem_wdata 0, i_ready 0, d_ready 0, i_rdata 0, d_rdata 0.
- Reset asserted mid-transaction:
  - The transaction is dropped with no ready pulse.
  - A write in ACCESS loses mem_write asynchronously; whether the memory commits that write is undefined.
  - Requesters reissue after reset.

## Structure
- memory_pkg (shared) holds:
  - state encodings: IDLE=2'd0, ACCESS=2'd1, WAIT=2'd2, DONE=2'd3;
  - grant-owner constants: GRANT_I=1'b0, GRANT_D=1'b1;
  - the default widths.
- Sub-module grant_select holds the winner logic and the streak counter.
  - Inputs: clock, reset_n, i_req, d_req, arbitrate strobe.
  - Output: grant.
- The FSM, the mem_* registers and the rdata registers stay in memory_arbiter.

## Test plan
- Single fetch: i_req with i_address=0x10, memory word 0xDEADBEEF -> mem_enable in cycle 1 with address 0x10; i_ready pulse in cycle 3 with i_rdata=0xDEADBEEF; stall_i high for cycles 0–2.
- Data write then read: d_write=1, d_address=0x40, d_wdata=0x12345678 -> mem_write in cycle 1, d_ready in cycle 3, d_rdata unchanged. A following read of 0x40 -> d_rdata=0x12345678 on d_ready.
- Simultaneous requests: i_req and d_req both raised in cycle 0 -> d_ready in cycle 3, i_ready in cycle 7; i_rdata untouched until cycle 7.
- Starvation bound: d_req held continuously with MAX_D_STREAK=4, i_req raised alongside -> exactly 4 d_ready pulses, then i_ready, then data resumes; streak reads 0 after the fetch grant.
- Reset mid-write: reset_n driven low during ACCESS -> mem_write and mem_enable go to 0 within the same cycle, no ready pulse, all outputs at reset values. After release, a reissued write completes in 4 cycles.
- Request dropped mid-transaction: d_req falls in WAIT -> d_ready still pulses once in DONE; no second access starts.

Source files
------------

// File: rtl/memory_pkg.sv
// Shared encodings and default widths for the
// L1I/L1D unified-memory arbiter.
package memory_pkg;

  localparam int ADDR_W_DEF   = 32;
  localparam int DATA_W_DEF   = 32;
  localparam int MAX_D_STREAK_DEF = 4;
  localparam int STREAK_W     = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/memory_arbiter_grant_select.sv
// Winner selection for the shared memory port plus the
// saturating data-streak counter that bounds fetch starvation.
module grant_select
  import memory_pkg::*;
#(
  parameter int MAX_D_STREAK = MAX_D_STREAK_DEF
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_req,
  input  logic d_req,
  input  logic arbitrate,
  output logic grant
);

  localparam logic [STREAK_W-1:0] MAX_S =
    STREAK_W'(MAX_D_STREAK);
  localparam logic [STREAK_W-1:0] SAT_S = '1;

  logic [STREAK_W-1:0] streak_q;
  logic [STREAK_W-1:0] streak_d;
  logic                d_wins;

  always_comb begin
    d_wins = d_req && !(i_req && (streak_q >= MAX_S));
    grant  = d_wins ? GRANT_D : GRANT_I;
    streak_d = streak_q;
    if (arbitrate) begin
      // Only a data grant that leaves a fetch waiting counts.
      if (d_wins && i_req) begin
        if (streak_q != SAT_S) begin
          streak_d = streak_q + 1'b1;
        end
      end else begin
        streak_d = '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Sequenced arbiter sharing one synchronous single-port
// memory between the fetch (L1I) and data (L1D) requesters.
module memory_arbiter
  import memory_pkg::*;
#(
  parameter int ADDR_WIDTH   = ADDR_W_DEF,
  parameter int DATA_WIDTH   = DATA_W_DEF,
  parameter int MAX_D_STREAK = MAX_D_STREAK_DEF
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic                  i_ready,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ready,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  stall_i,
  output logic                  stall_d,
  output logic                  mem_enable,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  wr_q, wr_d;
  logic                  mem_enable_q, mem_enable_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  arbitrate;
  logic                  grant;

  grant_select #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_grant (
    .clock    (clock),
    .reset_n  (reset_n),
    .i_req    (i_req),
    .d_req    (d_req),
    .arbitrate(arbitrate),
    .grant    (grant)
  );

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    wr_d          = wr_q;
    mem_enable_d  = mem_enable_q;
    mem_write_d   = mem_write_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    i_rdata_d     = i_rdata_q;
    d_rdata_d     = d_rdata_q;
    arbitrate     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          arbitrate    = 1'b1;
          owner_d      = grant;
          mem_enable_d = 1'b1;
          state_d      = ACCESS;
          if (grant == GRANT_D) begin
            mem_address_d = d_address;
            mem_wdata_d   = d_wdata;
            wr_d          = d_write;
            mem_write_d   = d_write;
          end else begin
            mem_address_d = i_address;
            wr_d          = 1'b0;
            mem_write_d   = 1'b0;
          end
        end
      end
      ACCESS: begin
        mem_enable_d = 1'b0;
        mem_write_d  = 1'b0;
        state_d      = WAIT;
      end
      WAIT: begin
        if (!wr_q) begin
          if (owner_q == GRANT_D) begin
            d_rdata_d = mem_rdata;
          end else begin
            i_rdata_d = mem_rdata;
          end
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      owner_q       <= GRANT_I;
      wr_q          <= 1'b0;
      mem_enable_q  <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      i_rdata_q     <= '0;
      d_rdata_q     <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      wr_q          <= wr_d;
      mem_enable_q  <= mem_enable_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      i_rdata_q     <= i_rdata_d;
      d_rdata_q     <= d_rdata_d;
    end
  end

  assign i_ready     = (state_q == DONE) && (owner_q == GRANT_I);
  assign d_ready     = (state_q == DONE) && (owner_q == GRANT_D);
  assign stall_i     = i_req && !i_ready;
  assign stall_d     = d_req && !d_ready;
  assign mem_enable  = mem_enable_q;
  assign mem_write   = mem_write_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;
  assign i_rdata     = i_rdata_q;
  assign d_rdata     = d_rdata_q;

endmodule
